// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge
// Core-side initiator for the UART peripheral's FIFO interface. It turns
// single-cycle CPU load/store strobes into TX-FIFO push pulses and RX-FIFO
// pop requests, behind a byte-wide register map:
//   addr 0 TXDATA (W), addr 1 RXDATA (R), addr 2 STATUS (R, clears flags),
//   addr 3 reserved (or IRQ_EN when the option is built in).
// STATUS layout: bit0 = RX data available, bit1 = rx_underflow (sticky),
//                bit2 = tx_drop (sticky), bits[7:3] = 0.
// Optional feature: define UART_BRIDGE_IRQ_EN to add o_uart_bridge_irq and a
// read/write IRQ_EN register at address 3 (bits[2:0] mask the STATUS bits).
module uart_bus_bridge #(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic       i_uart_bridge_clk,
    input  logic       i_uart_bridge_rst_n,
    input  logic [1:0] i_uart_bridge_addr,
    input  logic       i_uart_bridge_wen,
    input  logic       i_uart_bridge_ren,
    input  logic [7:0] i_uart_bridge_wdata,
    output logic [7:0] o_uart_bridge_rdata,
    output logic       o_uart_bridge_rvalid,
    output logic       o_uart_bridge_busy,
`ifdef UART_BRIDGE_IRQ_EN
    output logic       o_uart_bridge_irq,
`endif
    output logic       o_uart_tx_valid,
    output logic [7:0] o_uart_tx_pdata,
    input  logic       i_uart_fifo_full,
    output logic       o_uart_rx_request,
    input  logic [7:0] i_uart_rx_pdata,
    input  logic       i_uart_rx_empty
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_TX_WAIT = 2'd1,
        S_TX_PUSH = 2'd2,
        S_RX_POP  = 2'd3
    } state_t;

    localparam logic [1:0] A_TXDATA = 2'd0;
    localparam logic [1:0] A_RXDATA = 2'd1;
    localparam logic [1:0] A_STATUS = 2'd2;
    localparam logic [1:0] A_RSVD   = 2'd3;

    // TIMEOUT = 0 yields a zero-width CNT_W; keep at least one bit so the
    // counter stays legal (it is never compared in that configuration).
    localparam int            CW       = (CNT_W > 0) ? CNT_W : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_tx_valid;
    logic          r_rx_request;
    logic          r_rvalid;
    logic [7:0]    r_tx_pdata;
    logic [7:0]    r_rdata;
    logic          r_tx_drop;
    logic          r_rx_under;

    logic          w_accept;
    logic          w_wr;
    logic          w_rd;
    logic          w_tx_wr;
    logic          w_timeout;
    logic          w_drop_set;
    logic          w_under_set;
    logic          w_status_rd;
    logic          w_cfg_wr;
    logic          w_busy_nxt;
    logic          w_tx_valid_nxt;
    logic          w_rx_req_nxt;
    logic [7:0]    w_rdata_nxt;

`ifdef UART_BRIDGE_IRQ_EN
    logic [2:0]    r_irq_en;
    logic          r_irq;
`endif

    // Strobes are only honoured while not busy; a write wins over a read.
    assign w_accept    = ~r_busy;
    assign w_wr        = w_accept & i_uart_bridge_wen;
    assign w_rd        = w_accept & i_uart_bridge_ren & ~i_uart_bridge_wen;
    assign w_tx_wr     = w_wr & (i_uart_bridge_addr == A_TXDATA);
    assign w_timeout   = (TIMEOUT != 0) && (r_cnt == CNT_LAST);
    assign w_drop_set  = (r_state == S_TX_WAIT) & i_uart_fifo_full & w_timeout;
    assign w_under_set = w_rd & (i_uart_bridge_addr == A_RXDATA) & i_uart_rx_empty;
    assign w_status_rd = w_rd & (i_uart_bridge_addr == A_STATUS);

`ifdef UART_BRIDGE_IRQ_EN
    assign w_cfg_wr = w_wr & (i_uart_bridge_addr == A_RSVD);
`else
    assign w_cfg_wr = 1'b0;
`endif

    // State register; reset discards any pending push or pop.
    always_ff @(posedge i_uart_bridge_clk or negedge i_uart_bridge_rst_n) begin
        if (!i_uart_bridge_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: accept in IDLE, wait out back-pressure, single-cycle push/pop.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_tx_wr) begin
                    w_state_nxt = S_TX_WAIT;
                end else if (w_rd && (i_uart_bridge_addr == A_RXDATA) && !i_uart_rx_empty) begin
                    w_state_nxt = S_RX_POP;
                end
            end
            S_TX_WAIT: begin
                if (!i_uart_fifo_full) begin
                    w_state_nxt = S_TX_PUSH;
                end else if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_TX_PUSH: w_state_nxt = S_IDLE;
            S_RX_POP:  w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the next state so the outputs below come straight off flops.
    always_comb begin
        w_busy_nxt     = (w_state_nxt != S_IDLE) | w_cfg_wr;
        w_tx_valid_nxt = (w_state_nxt == S_TX_PUSH);
        w_rx_req_nxt   = (w_state_nxt == S_RX_POP);
    end

    // Read-data mux for the register selected by an accepted read strobe.
    always_comb begin
        w_rdata_nxt = 8'h00;
        case (i_uart_bridge_addr)
            A_RXDATA: w_rdata_nxt = i_uart_rx_empty ? 8'h00 : i_uart_rx_pdata;
            A_STATUS: w_rdata_nxt = {5'b0, r_tx_drop, r_rx_under, ~i_uart_rx_empty};
`ifdef UART_BRIDGE_IRQ_EN
            A_RSVD:   w_rdata_nxt = {5'b0, r_irq_en};
`endif
            default:  w_rdata_nxt = 8'h00;
        endcase
    end

    // Registered handshake outputs.
    always_ff @(posedge i_uart_bridge_clk or negedge i_uart_bridge_rst_n) begin
        if (!i_uart_bridge_rst_n) begin
            r_busy       <= 1'b0;
            r_tx_valid   <= 1'b0;
            r_rx_request <= 1'b0;
        end else begin
            r_busy       <= w_busy_nxt;
            r_tx_valid   <= w_tx_valid_nxt;
            r_rx_request <= w_rx_req_nxt;
        end
    end

    // TX byte latch, timeout counter, read data and sticky flags (set beats clear).
    always_ff @(posedge i_uart_bridge_clk or negedge i_uart_bridge_rst_n) begin
        if (!i_uart_bridge_rst_n) begin
            r_tx_pdata <= 8'h00;
            r_cnt      <= '0;
            r_rdata    <= 8'h00;
            r_rvalid   <= 1'b0;
            r_tx_drop  <= 1'b0;
            r_rx_under <= 1'b0;
        end else begin
            r_rvalid <= w_rd;
            if (w_tx_wr) begin
                r_tx_pdata <= i_uart_bridge_wdata;
                r_cnt      <= '0;
            end else if ((r_state == S_TX_WAIT) && i_uart_fifo_full && !w_timeout) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_rd) begin
                r_rdata <= w_rdata_nxt;
            end
            r_tx_drop  <= w_drop_set  | (r_tx_drop  & ~w_status_rd);
            r_rx_under <= w_under_set | (r_rx_under & ~w_status_rd);
        end
    end

`ifdef UART_BRIDGE_IRQ_EN
    // IRQ enable register and level interrupt, re-evaluated every cycle.
    always_ff @(posedge i_uart_bridge_clk or negedge i_uart_bridge_rst_n) begin
        if (!i_uart_bridge_rst_n) begin
            r_irq_en <= 3'b000;
            r_irq    <= 1'b0;
        end else begin
            if (w_cfg_wr) begin
                r_irq_en <= i_uart_bridge_wdata[2:0];
            end
            r_irq <= |(r_irq_en & {r_tx_drop, r_rx_under, ~i_uart_rx_empty});
        end
    end

    assign o_uart_bridge_irq = r_irq;
`endif

    assign o_uart_bridge_rdata  = r_rdata;
    assign o_uart_bridge_rvalid = r_rvalid;
    assign o_uart_bridge_busy   = r_busy;
    assign o_uart_tx_valid      = r_tx_valid;
    assign o_uart_tx_pdata      = r_tx_pdata;
    assign o_uart_rx_request    = r_rx_request;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// tb_uart_bus_bridge
// Self-checking bench for uart_bus_bridge (TIMEOUT = 8). A small environment
// model holds the RX FIFO contents as a queue and the expected sticky flags;
// expected timing of pushes/drops is computed from the access rules.
module tb_uart_bus_bridge;

    localparam int TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] addr;
    logic       wen;
    logic       ren;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       rvalid;
    logic       busy;
    logic       tx_valid;
    logic [7:0] tx_pdata;
    logic       fifo_full;
    logic       rx_request;
    logic [7:0] rx_pdata;
    logic       rx_empty;
`ifdef UART_BRIDGE_IRQ_EN
    logic       irq;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] rxq[$];
    bit         m_drop;
    bit         m_under;

    uart_bus_bridge #(.TIMEOUT(TIMEOUT)) dut (
        .i_uart_bridge_clk    (clk),
        .i_uart_bridge_rst_n  (rst_n),
        .i_uart_bridge_addr   (addr),
        .i_uart_bridge_wen    (wen),
        .i_uart_bridge_ren    (ren),
        .i_uart_bridge_wdata  (wdata),
        .o_uart_bridge_rdata  (rdata),
        .o_uart_bridge_rvalid (rvalid),
        .o_uart_bridge_busy   (busy),
`ifdef UART_BRIDGE_IRQ_EN
        .o_uart_bridge_irq    (irq),
`endif
        .o_uart_tx_valid      (tx_valid),
        .o_uart_tx_pdata      (tx_pdata),
        .i_uart_fifo_full     (fifo_full),
        .o_uart_rx_request    (rx_request),
        .i_uart_rx_pdata      (rx_pdata),
        .i_uart_rx_empty      (rx_empty)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rx();
        rx_empty = (rxq.size() == 0);
        rx_pdata = (rxq.size() != 0) ? rxq[0] : 8'h00;
    endtask

    function automatic logic [7:0] exp_status();
        return {5'b0, m_drop, m_under, (rxq.size() != 0)};
    endfunction

    // Issue a TXDATA write with the FIFO full for the first nfull cycles after it.
    task automatic do_write(input logic [7:0] b, input int nfull,
                            output int pushes, output int push_at, output int idle_at,
                            output logic [7:0] pbyte, output logic busy1);
        pushes = 0; push_at = 0; idle_at = 0; pbyte = 8'h00; busy1 = 1'b0;
        addr = 2'd0; wdata = b; wen = 1'b1; ren = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 1) busy1 = busy;
            if (tx_valid) begin
                pushes++;
                push_at = k;
                pbyte   = tx_pdata;
            end
            if (!busy && idle_at == 0) idle_at = k;
            wen = 1'b0;
            fifo_full = (k <= nfull);
        end
        fifo_full = 1'b0;
    endtask

    // Issue a read strobe (optionally with wen too) and watch four cycles.
    task automatic do_read(input logic [1:0] a, input logic also_wen,
                           output logic [7:0] rd, output logic rv1, output logic req1,
                           output int nrv, output int nreq);
        addr = a; ren = 1'b1; wen = also_wen; wdata = 8'($urandom);
        rd = 8'h00; rv1 = 1'b0; req1 = 1'b0; nrv = 0; nreq = 0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 1) begin
                rv1  = rvalid;
                req1 = rx_request;
            end
            if (rvalid) begin
                nrv++;
                rd = rdata;
            end
            if (rx_request) begin
                nreq++;
                if (rxq.size() != 0) void'(rxq.pop_front());
            end
            ren = 1'b0;
            wen = 1'b0;
            set_rx();
        end
    endtask

    task automatic test_reset();
        logic [7:0] rd;
        logic       rv1, req1;
        int         nrv, nreq, pushes, busy_cnt;
        rst_n = 1'b0; wen = 1'b0; ren = 1'b0; addr = 2'd0; wdata = 8'h00; fifo_full = 1'b0;
        rxq.delete(); set_rx();
        m_drop = 0; m_under = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, tx_valid, rx_request, rvalid, tx_pdata, rdata} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %05h required 00000",
                     {busy, tx_valid, rx_request, rvalid, tx_pdata, rdata});
        end
        rst_n = 1'b1;
        tick();
        addr = 2'd0; wdata = 8'h5A; wen = 1'b1; fifo_full = 1'b1;
        tick();
        wen = 1'b0;
        tick();
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_busy: got %0b required 1", busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, tx_valid, tx_pdata} !== 10'h0) begin
            errors++;
            $display("FAIL reset_midop_outputs: got %03h required 000", {busy, tx_valid, tx_pdata});
        end
        tick();
        rst_n = 1'b1; fifo_full = 1'b0;
        pushes = 0; busy_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (tx_valid) pushes++;
            if (busy) busy_cnt++;
        end
        checks++;
        if (pushes !== 0 || busy_cnt !== 0) begin
            errors++;
            $display("FAIL reset_no_push: pushes %0d busy %0d required 0 0", pushes, busy_cnt);
        end
        do_read(2'd2, 1'b0, rd, rv1, req1, nrv, nreq);
        checks++;
        if (rd !== 8'h00 || rv1 !== 1'b1) begin
            errors++;
            $display("FAIL reset_status: got %02h rvalid %0b required 00 rvalid 1", rd, rv1);
        end
    endtask

    task automatic test_write();
        logic [7:0] b, pbyte;
        logic       busy1;
        int         pushes, push_at, idle_at;
        for (int i = 0; i < 6; i++) begin
            b = (i == 0) ? 8'hA5 : 8'($urandom);
            do_write(b, 0, pushes, push_at, idle_at, pbyte, busy1);
            checks++;
            if (busy1 !== 1'b1 || idle_at !== 3) begin
                errors++;
                $display("FAIL write_busy: busy@1 %0b idle_at %0d required 1 3", busy1, idle_at);
            end
            checks++;
            if (pushes !== 1 || push_at !== 2 || pbyte !== b) begin
                errors++;
                $display("FAIL write_push: pushes %0d at %0d byte %02h required 1 at 2 byte %02h",
                         pushes, push_at, pbyte, b);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] b, pbyte, rd, exp;
        logic       busy1, rv1, req1;
        int         pushes, push_at, idle_at, nrv, nreq, nf, exp_push, exp_idle;
        for (int i = 0; i < 8; i++) begin
            case (i)
                0: nf = 5;
                1: nf = 20;
                2: nf = TIMEOUT - 1;
                3: nf = TIMEOUT;
                default: nf = int'($urandom_range(0, 14));
            endcase
            b = 8'($urandom);
            exp_push = (nf < TIMEOUT) ? 1 : 0;
            exp_idle = (nf < TIMEOUT) ? nf + 3 : TIMEOUT + 1;
            do_write(b, nf, pushes, push_at, idle_at, pbyte, busy1);
            if (nf >= TIMEOUT) m_drop = 1;
            checks++;
            if (pushes !== exp_push || idle_at !== exp_idle) begin
                errors++;
                $display("FAIL bp_outcome full=%0d: pushes %0d idle_at %0d required %0d %0d",
                         nf, pushes, idle_at, exp_push, exp_idle);
            end
            if (exp_push == 1) begin
                checks++;
                if (push_at !== nf + 2 || pbyte !== b) begin
                    errors++;
                    $display("FAIL bp_push full=%0d: at %0d byte %02h required at %0d byte %02h",
                             nf, push_at, pbyte, nf + 2, b);
                end
            end
            for (int r = 0; r < 2; r++) begin
                exp = exp_status();
                do_read(2'd2, 1'b0, rd, rv1, req1, nrv, nreq);
                m_drop = 0; m_under = 0;
                checks++;
                if (rd !== exp || rv1 !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_status full=%0d read%0d: got %02h required %02h",
                             nf, r, rd, exp);
                end
            end
        end
    endtask

    task automatic test_rx_pop();
        logic [7:0] rd, exp;
        logic       rv1, req1;
        int         nrv, nreq, n;
        rxq.delete();
        rxq.push_back(8'h3C);
        for (int i = 0; i < 4; i++) rxq.push_back(8'($urandom));
        set_rx();
        n = rxq.size();
        for (int i = 0; i < n; i++) begin
            exp = rxq[0];
            do_read(2'd1, 1'b0, rd, rv1, req1, nrv, nreq);
            checks++;
            if (rd !== exp || rv1 !== 1'b1 || nrv !== 1) begin
                errors++;
                $display("FAIL rx_data: got %02h rvalid@1 %0b count %0d required %02h 1 1",
                         rd, rv1, nrv, exp);
            end
            checks++;
            if (req1 !== 1'b1 || nreq !== 1) begin
                errors++;
                $display("FAIL rx_request: req@1 %0b count %0d required 1 1", req1, nreq);
            end
            checks++;
            if (rdata !== exp) begin
                errors++;
                $display("FAIL rx_hold: got %02h required %02h", rdata, exp);
            end
        end
        checks++;
        if (rxq.size() !== 0) begin
            errors++;
            $display("FAIL rx_drained: left %0d required 0", rxq.size());
        end
    endtask

    task automatic test_underflow();
        logic [7:0] rd, exp;
        logic       rv1, req1;
        int         nrv, nreq;
        rxq.delete(); set_rx();
        do_read(2'd1, 1'b0, rd, rv1, req1, nrv, nreq);
        m_under = 1;
        checks++;
        if (rd !== 8'h00 || rv1 !== 1'b1 || nreq !== 0) begin
            errors++;
            $display("FAIL under_read: got %02h rvalid %0b req %0d required 00 1 0", rd, rv1, nreq);
        end
        for (int r = 0; r < 2; r++) begin
            exp = exp_status();
            do_read(2'd2, 1'b0, rd, rv1, req1, nrv, nreq);
            m_drop = 0; m_under = 0;
            checks++;
            if (rd !== exp) begin
                errors++;
                $display("FAIL under_status read%0d: got %02h required %02h", r, rd, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a, pbyte;
        int         pushes, push_at, nrv, nreq;
        rxq.delete();
        rxq.push_back(8'($urandom));
        set_rx();
        a = 8'($urandom);
        pushes = 0; push_at = 0; pbyte = 8'h00; nrv = 0; nreq = 0;
        addr = 2'd0; wdata = a; wen = 1'b1; ren = 1'b0; fifo_full = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (tx_valid) begin
                pushes++;
                push_at = k;
                pbyte   = tx_pdata;
            end
            if (rvalid) nrv++;
            if (rx_request) nreq++;
            if (k == 1) begin
                wdata = ~a;
                wen   = 1'b1;
            end else if (k == 2) begin
                wen  = 1'b0;
                ren  = 1'b1;
                addr = 2'd1;
            end else begin
                ren = 1'b0;
            end
        end
        checks++;
        if (pushes !== 1 || push_at !== 2 || pbyte !== a) begin
            errors++;
            $display("FAIL busy_ignore_push: pushes %0d at %0d byte %02h required 1 at 2 byte %02h",
                     pushes, push_at, pbyte, a);
        end
        checks++;
        if (nrv !== 0 || nreq !== 0) begin
            errors++;
            $display("FAIL busy_ignore_read: rvalid %0d req %0d required 0 0", nrv, nreq);
        end
        rxq.delete(); set_rx();
    endtask

    task automatic test_misc();
        logic [7:0] rd, exp;
        logic       rv1, req1;
        int         nrv, nreq;
        rxq.delete(); set_rx();
        do_read(2'd0, 1'b0, rd, rv1, req1, nrv, nreq);
        checks++;
        if (rd !== 8'h00 || rv1 !== 1'b1 || nreq !== 0) begin
            errors++;
            $display("FAIL read_txdata: got %02h rvalid %0b required 00 1", rd, rv1);
        end
        do_read(2'd3, 1'b0, rd, rv1, req1, nrv, nreq);
        checks++;
        if (rd !== 8'h00 || rv1 !== 1'b1) begin
            errors++;
            $display("FAIL read_addr3: got %02h rvalid %0b required 00 1", rd, rv1);
        end
        do_read(2'd1, 1'b0, rd, rv1, req1, nrv, nreq);
        m_under = 1;
        do_read(2'd2, 1'b1, rd, rv1, req1, nrv, nreq);
        checks++;
        if (nrv !== 0) begin
            errors++;
            $display("FAIL wen_wins_status: rvalid count %0d required 0", nrv);
        end
        rxq.push_back(8'($urandom));
        set_rx();
        do_read(2'd1, 1'b1, rd, rv1, req1, nrv, nreq);
        checks++;
        if (nrv !== 0 || nreq !== 0 || rxq.size() !== 1) begin
            errors++;
            $display("FAIL wen_wins_rx: rvalid %0d req %0d left %0d required 0 0 1",
                     nrv, nreq, rxq.size());
        end
        exp = exp_status();
        do_read(2'd2, 1'b0, rd, rv1, req1, nrv, nreq);
        m_drop = 0; m_under = 0;
        checks++;
        if (rd !== exp) begin
            errors++;
            $display("FAIL status_after_noop: got %02h required %02h", rd, exp);
        end
        rxq.delete(); set_rx();
    endtask

    initial begin
        test_reset();
        test_write();
        test_backpressure();
        test_rx_pop();
        test_underflow();
        test_back_to_back();
        test_misc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_bus_bridge.md
Name: uart_bus_bridge

Overview:
- Core-side initiator for the UART peripheral's parallel interface: turns single-cycle CPU load/store accesses into TX-FIFO push pulses and RX-FIFO pop requests.
- Sits between the RISC-V data-memory decode and the UART peripheral top.
- Provides a byte-wide register map (TXDATA/RXDATA/STATUS) with a busy handshake, bounded TX back-pressure wait and sticky error flags.

Parameters:
- TIMEOUT, 1024, max cycles spent waiting on a full TX FIFO before the byte is dropped; 0 = wait forever.
- CNT_W, $clog2(TIMEOUT+1), timeout counter width (derived, do not override).

Ports:
- i_uart_bridge_clk  in  1  bridge clock, same clock as the peripheral's core-side FIFO ports
- i_uart_bridge_rst_n  in  1  reset
- i_uart_bridge_addr  in  2  0=TXDATA, 1=RXDATA, 2=STATUS, 3=reserved
- i_uart_bridge_wen  in  1  write strobe, one cycle
- i_uart_bridge_ren  in  1  read strobe, one cycle
- i_uart_bridge_wdata  in  8  write data
- o_uart_bridge_rdata  out  8  registered read data
- o_uart_bridge_rvalid  out  1  one-cycle pulse, rdata valid
- o_uart_bridge_busy  out  1  high while an access is in progress
- o_uart_tx_valid  out  1  TX FIFO push pulse
- o_uart_tx_pdata  out  8  TX byte
- i_uart_fifo_full  in  1  TX FIFO full
- o_uart_rx_request  out  1  RX FIFO pop pulse
- i_uart_rx_pdata  in  8  RX FIFO head, first-word-fall-through
- i_uart_rx_empty  in  1  RX FIFO empty

Behaviour:
- Clock and reset: one clock, i_uart_bridge_clk. Reset i_uart_bridge_rst_n is asynchronous and active-low.
- Reset values: all outputs 0; state IDLE; sticky flags 0; counter 0.
- State machine states: IDLE, TX_WAIT, TX_PUSH, RX_POP.
- Busy rule: o_uart_bridge_busy = (state != IDLE), registered. Strobes are accepted only in IDLE. Strobes while busy are ignored (no side effects).
- Strobe conflicts: wen and ren together resolve to wen. Writes to RXDATA, STATUS or 3 are no-ops. A read of TXDATA or addr 3 returns 0 with rvalid one cycle later.
- TXDATA write in IDLE (cycle N): latch wdata into o_uart_tx_pdata, clear the counter, go to TX_WAIT.
- TX_WAIT:
  - If !i_uart_fifo_full: go to TX_PUSH.
  - Else if TIMEOUT != 0 and counter == TIMEOUT-1: set sticky tx_drop and return to IDLE without a push.
  - Else: counter += 1.
- TX_PUSH: o_uart_tx_valid = 1 for exactly this cycle, then IDLE. Minimum write occupancy is 3 cycles (N+1 WAIT, N+2 PUSH, IDLE at N+3). This guarantees the full flag seen in WAIT already reflects the previous push.
- RXDATA read in IDLE (cycle N):
  - If !i_uart_rx_empty: rdata <= i_uart_rx_pdata, rvalid = 1 at N+1. State RX_POP at N+1 drives o_uart_rx_request = 1 for that one cycle, then IDLE.
  - If empty: rdata <= 0, rvalid at N+1, set sticky rx_underflow, stay IDLE, no pop.
- STATUS read: rdata <= {5'b0, tx_drop, rx_underflow, ~i_uart_rx_empty} at bit positions [7:3],[2],[1],[0]. Wait — layout is bit0 = ~i_uart_rx_empty, bit1 = rx_underflow, bit2 = tx_drop, bits[7:3] = 0. rvalid at N+1. Both sticky flags clear on this read. If a set and a clear coincide in the same cycle, the set wins.
- Reset mid-operation: a pending TX byte is discarded with no push; an in-flight pop is not issued.
- o_uart_bridge_rdata holds its last value when rvalid is low.

Optional Feature:
- Macro: UART_BRIDGE_IRQ_EN.
- With the macro defined:
  - Adds output o_uart_bridge_irq (1 bit, registered, reset 0).
  - Address 3 becomes IRQ_EN, a read/write register, bits[2:0], reset 0.
  - irq = |(IRQ_EN & {tx_drop, rx_underflow, ~i_uart_rx_empty}), updated every cycle.
  - Address 3 writes complete in 1 cycle, with busy high for one cycle.
- Without the macro: no irq port; address 3 reads 0 and writes are ignored.

Test Plan:
- Reset: assert rst_n low mid-TX_WAIT with fifo_full=1 -> all outputs 0, no o_uart_tx_valid after release, STATUS reads 0x00.
- Normal write: TXDATA write 0xA5, fifo_full=0 -> busy for cycles N+1..N+2; o_uart_tx_valid pulse at N+2 with pdata 0xA5; busy low at N+3.
- Back-pressure: TIMEOUT=8, fifo_full=1 for 5 cycles then 0 -> push of the byte after full drops, tx_drop stays 0. With full held for 20 cycles -> no push, return to IDLE after 8 WAIT cycles, STATUS = 0x04, then the next STATUS read = 0x00.
- RX pop: rx_empty=0, rx_pdata=0x3C, RXDATA read -> rdata=0x3C with rvalid at N+1, o_uart_rx_request single pulse at N+1.
- Underflow: rx_empty=1, RXDATA read -> rdata=0x00, no request, STATUS bit1=1. Repeat with rx_underflow set in the same cycle as a STATUS read -> flag stays 1.
- Busy ignore: issue a second TXDATA write at N+1 -> exactly one push, pdata equals the first byte.
